uart_wr_pack: RTL and testbench

Counterpart of the UART read-side drain on the SDRAM path: sits between uart_rx (clk_50M domain) and the write FIFO port of sdram_interface. Converts rx_flag/rx_data byte strobes into fifo_wr_req/fifo_wr_data word writes. After the line goes idle, pads the trailing partial burst with filler words. The SDRAM write engine only fires on whole bursts of wr_burst_len, so this padding guarantees the tail of a transfer reaches SDRAM.

---
 rtl/uart_sdram_pkg.sv | 20 ++
 rtl/uart_wr_pack_if.sv | 18 +
 rtl/uart_idle_timer.sv | 26 ++
 rtl/uart_wr_pack.sv | 158 +++++++++++++++
 tb/tb_uart_wr_pack.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sdram_pkg.sv
// rtl/uart_sdram_pkg.sv - shared types and constants for the UART-to-SDRAM write path
package uart_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        PAD  = 2'd2
    } wr_state_t;

    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    // 50 MHz / 9600 Bd; two 10-bit characters of silence ends a transfer.
    localparam int BAUD_CYCLES          = 5208;
    localparam int IDLE_TIMEOUT_DEFAULT = 20 * BAUD_CYCLES;

    function automatic logic [10:0] eff_len(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_wr_pack_if.sv
// rtl/uart_wr_pack_if.sv - byte-in / word-out bus between uart_rx, uart_wr_pack and the write FIFO
interface uart_wr_pack_if;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic        fifo_wr_rst_busy;
    logic        fifo_wr_req;
    logic [15:0] fifo_wr_data;

    modport master (
        output rx_data, rx_flag, fifo_wr_rst_busy,
        input  fifo_wr_req, fifo_wr_data
    );

    modport slave (
        input  rx_data, rx_flag, fifo_wr_rst_busy,
        output fifo_wr_req, fifo_wr_data
    );
endinterface

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - line-idle counter with clear, enable and one-cycle expire pulse
module uart_idle_timer
    import uart_sdram_pkg::*;
#(
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT,
    parameter int TMR_W        = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [TMR_W-1:0] count;

    // A clear in the same cycle always beats expiry.
    assign expire = en && !clr && (count == TMR_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || expire) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_wr_pack.sv
// rtl/uart_wr_pack.sv - packs uart_rx bytes into write-FIFO words and pads the trailing burst after idle
// Build option UART_WR_PACK_EN: two bytes per word (low byte first); otherwise one zero-extended byte per word.
module uart_wr_pack
    import uart_sdram_pkg::*;
#(
    parameter int         IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT,
    parameter int         TMR_W        = 17,
    parameter logic [7:0] PAD_BYTE     = PAD_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    uart_wr_pack_if.slave bus,
    input  logic [9:0]    burst_len,
    output logic          pad_active,
    output logic [15:0]   drop_cnt
);
`ifdef UART_WR_PACK_EN
    localparam bit          PACK_EN  = 1'b1;
    localparam logic [15:0] PAD_WORD = {PAD_BYTE, PAD_BYTE};
    logic [7:0]  lo_reg;
`else
    localparam bit          PACK_EN  = 1'b0;
    localparam logic [15:0] PAD_WORD = {8'h00, PAD_BYTE};
`endif

    wr_state_t   state, state_n;
    logic [9:0]  burst_cnt, len_reg;
    logic        hold_valid, retry_valid;
    logic [7:0]  hold_data, in_byte;
    logic [15:0] retry_data, new_word;
    logic        busy, stall, accept, proc, drop, pending;
    logic        tmr_clr, tmr_en, expire, cnt_wrap, new_wr, new_pad;
    logic [10:0] len_eff, cnt_inc;

    assign busy     = bus.fifo_wr_rst_busy;
    assign stall    = busy || retry_valid;
    assign accept   = bus.rx_flag && !busy;
    // A held byte is consumed before any newly arriving one.
    assign proc     = !stall && (state != PAD) && (hold_valid || bus.rx_flag);
    assign in_byte  = hold_valid ? hold_data : bus.rx_data;
    assign drop     = bus.rx_flag && (busy || (hold_valid && !proc));
    assign pending  = (state != IDLE) || (burst_cnt != 10'd0);
    assign tmr_clr  = accept || proc || !pending || (state == PAD);
    assign tmr_en   = !stall && pending && (state != PAD);
    assign len_eff  = eff_len((burst_cnt != 10'd0) ? len_reg : burst_len);
    assign cnt_inc  = {1'b0, burst_cnt} + 11'd1;
    assign cnt_wrap = (cnt_inc >= len_eff);

    uart_idle_timer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (proc)        state_n = PACK_EN ? HALF : IDLE;
                else if (expire) state_n = PAD;
            end
`ifdef UART_WR_PACK_EN
            HALF: begin
                if (proc)        state_n = IDLE;
                else if (expire) state_n = cnt_wrap ? IDLE : PAD;
            end
`endif
            PAD:     if (!stall && cnt_wrap) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        new_wr   = 1'b0;
        new_pad  = 1'b0;
        new_word = '0;
        case (state)
            IDLE: if (proc && !PACK_EN) begin
                new_wr   = 1'b1;
                new_word = {8'h00, in_byte};
            end
`ifdef UART_WR_PACK_EN
            HALF: if (proc) begin
                new_wr   = 1'b1;
                new_word = {in_byte, lo_reg};
            end else if (expire) begin
                new_wr   = 1'b1;
                new_word = {PAD_BYTE, lo_reg};
            end
`endif
            PAD: if (!stall) begin
                new_wr   = 1'b1;
                new_pad  = 1'b1;
                new_word = PAD_WORD;
            end
            default: ;
        endcase
    end

`ifdef UART_WR_PACK_EN
    always_ff @(posedge clk) begin
        if (rst)                         lo_reg <= '0;
        else if (state == IDLE && proc)  lo_reg <= in_byte;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt        <= '0;
            len_reg          <= '0;
            hold_valid       <= 1'b0;
            hold_data        <= '0;
            retry_valid      <= 1'b0;
            retry_data       <= '0;
            bus.fifo_wr_req  <= 1'b0;
            bus.fifo_wr_data <= '0;
            pad_active       <= 1'b0;
            drop_cnt         <= '0;
        end else begin
            if (new_wr) begin
                burst_cnt <= cnt_wrap ? 10'd0 : cnt_inc[9:0];
                if (burst_cnt == 10'd0) len_reg <= burst_len;
            end
            if (state != PAD && state_n == PAD) len_reg <= burst_len;

            bus.fifo_wr_req  <= new_wr || (retry_valid && !busy);
            bus.fifo_wr_data <= retry_valid ? retry_data : new_word;
            pad_active       <= new_pad;

            // A strobe the FIFO saw while busy was lost; replay it once busy drops.
            if (bus.fifo_wr_req && busy) begin
                retry_valid <= 1'b1;
                retry_data  <= bus.fifo_wr_data;
            end else if (!busy) begin
                retry_valid <= 1'b0;
            end

            if (accept && (hold_valid == proc)) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.rx_data;
            end else if (proc && hold_valid) begin
                hold_valid <= 1'b0;
            end

            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_uart_wr_pack.sv
// tb/tb_uart_wr_pack.sv - scoreboard bench for uart_wr_pack (expectations follow UART_WR_PACK_EN)
`timescale 1ns/1ps
module tb_uart_wr_pack;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  burst_len = 10'd4;
    logic        pad_active;
    logic [15:0] drop_cnt;

    uart_wr_pack_if bus();

    uart_wr_pack #(
        .IDLE_TIMEOUT (TMO),
        .TMR_W        (17),
        .PAD_BYTE     (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .burst_len  (burst_len),
        .pad_active (pad_active),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;
    int          pad_seen = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_word;

    // Scoreboard: each observed write is {pad_active, fifo_wr_data}.
    always @(negedge clk) begin
        if (bus.fifo_wr_req === 1'b1) begin
            wr_count++;
            if (pad_active === 1'b1) pad_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got=%h pad=%b", bus.fifo_wr_data, pad_active);
            end else begin
                exp_word = exp_q.pop_front();
                if ({pad_active, bus.fifo_wr_data} !== exp_word) begin
                    errors++;
                    $display("FAIL write_word got=%h pad=%b expected=%h pad=%b",
                             bus.fifo_wr_data, pad_active, exp_word[15:0], exp_word[16]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_flag = 1'b1;
        bus.rx_data = b;
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        wr_count = 0;
        pad_seen = 0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_count < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.fifo_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b expected=0", bus.fifo_wr_req); end
        checks++;
        if (bus.fifo_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h expected=0000", bus.fifo_wr_data); end
        checks++;
        if ({pad_active, drop_cnt} !== 17'h0) begin errors++; $display("FAIL reset_pad_drop got=%b/%0d expected=0/0", pad_active, drop_cnt); end
    endtask

    task automatic test_full_burst();
        burst_len = 10'd4;
        do_reset();
`ifdef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h2211});
        exp_q.push_back({1'b0, 16'h4433});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000});
`else
        exp_q.push_back({1'b0, 16'h0011});
        exp_q.push_back({1'b0, 16'h0022});
        exp_q.push_back({1'b0, 16'h0033});
        exp_q.push_back({1'b0, 16'h0044});
`endif
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_writes(4, 200);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 4 || exp_q.size() != 0) begin errors++; $display("FAIL full_burst_count got=%0d expected=4", wr_count); end
        checks++;
`ifdef UART_WR_PACK_EN
        if (pad_seen !== 2) begin errors++; $display("FAIL full_burst_pads got=%0d expected=2", pad_seen); end
`else
        if (pad_seen !== 0) begin errors++; $display("FAIL full_burst_pads got=%0d expected=0", pad_seen); end
`endif
    endtask

    task automatic test_half_flush();
        burst_len = 10'd4;
        do_reset();
`ifdef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h2211});
        exp_q.push_back({1'b0, 16'h0033});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000});
`else
        exp_q.push_back({1'b0, 16'h0011});
        exp_q.push_back({1'b0, 16'h0022});
        exp_q.push_back({1'b0, 16'h0033});
        exp_q.push_back({1'b1, 16'h0000});
`endif
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_writes(4, 200);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 4 || exp_q.size() != 0) begin errors++; $display("FAIL half_flush_count got=%0d expected=4", wr_count); end
    endtask

    task automatic test_single_len1();
        burst_len = 10'd1;
        do_reset();
        exp_q.push_back({1'b0, 16'h00A5});
`ifndef UART_WR_PACK_EN
        @(posedge clk); #1;
        bus.rx_flag = 1'b1;
        bus.rx_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (bus.fifo_wr_req !== 1'b0) begin errors++; $display("FAIL latency_early got=%b expected=0", bus.fifo_wr_req); end
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fifo_wr_req !== 1'b1) begin errors++; $display("FAIL latency_one got=%b expected=1", bus.fifo_wr_req); end
`else
        send_byte(8'hA5);
`endif
        wait_writes(1, 200);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 1 || pad_seen !== 0) begin errors++; $display("FAIL len1_count got=%0d/%0d expected=1/0", wr_count, pad_seen); end
    endtask

    task automatic test_pad_hold();
        burst_len = 10'd8;
        do_reset();
`ifdef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h0201});
`else
        exp_q.push_back({1'b0, 16'h0001});
`endif
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h005A});
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b1, 16'h0000});
        send_byte(8'h01);
`ifdef UART_WR_PACK_EN
        send_byte(8'h02);
`endif
        for (int i = 0; i < 200 && pad_seen < 1; i++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        bus.rx_flag = 1'b1;
        bus.rx_data = 8'h5A;
        @(posedge clk); #1;
        bus.rx_data = 8'h5B;
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
        wait_writes(16, 400);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 16 || exp_q.size() != 0) begin errors++; $display("FAIL pad_hold_count got=%0d expected=16", wr_count); end
        checks++;
        if (pad_seen !== 14) begin errors++; $display("FAIL pad_hold_pads got=%0d expected=14", pad_seen); end
        checks++;
        if (drop_cnt !== 16'd1) begin errors++; $display("FAIL pad_hold_drop got=%0d expected=1", drop_cnt); end
    endtask

    task automatic test_busy();
        int w0;
        burst_len = 10'd1;
        do_reset();
`ifndef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h0011});
`endif
        send_byte(8'h11);
        repeat (3) @(posedge clk);
        #1;
        bus.fifo_wr_rst_busy = 1'b1;
        w0 = wr_count;
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        repeat (14) @(posedge clk);
        #1;
        bus.fifo_wr_rst_busy = 1'b0;
        checks++;
        if (wr_count !== w0) begin errors++; $display("FAIL busy_writes got=%0d expected=%0d", wr_count, w0); end
        checks++;
        if (drop_cnt !== 16'd3) begin errors++; $display("FAIL busy_drop got=%0d expected=3", drop_cnt); end
`ifdef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h2211});
        send_byte(8'h22);
        wait_writes(1, 200);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 1 || exp_q.size() != 0) begin errors++; $display("FAIL busy_resume got=%0d expected=1", wr_count); end
`else
        exp_q.push_back({1'b0, 16'h0022});
        send_byte(8'h22);
        wait_writes(2, 200);
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 2 || exp_q.size() != 0) begin errors++; $display("FAIL busy_resume got=%0d expected=2", wr_count); end
`endif
    endtask

    task automatic test_reset_in_pad();
        burst_len = 10'd8;
        do_reset();
`ifdef UART_WR_PACK_EN
        exp_q.push_back({1'b0, 16'h0201});
`else
        exp_q.push_back({1'b0, 16'h0001});
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 16'h0000});
        send_byte(8'h01);
`ifdef UART_WR_PACK_EN
        send_byte(8'h02);
`endif
        for (int i = 0; i < 200 && pad_seen < 4; i++) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.fifo_wr_req, pad_active} !== 2'b00) begin errors++; $display("FAIL rst_pad_outputs got=%b%b expected=00", bus.fifo_wr_req, pad_active); end
        checks++;
        if ({bus.fifo_wr_data, drop_cnt} !== 32'h0) begin errors++; $display("FAIL rst_pad_data got=%h/%h expected=0/0", bus.fifo_wr_data, drop_cnt); end
        #1;
        rst = 1'b0;
        repeat (3 * TMO) @(negedge clk);
        #1;
        checks++;
        if (wr_count !== 5 || pad_seen !== 4 || exp_q.size() != 0) begin errors++; $display("FAIL rst_pad_after got=%0d/%0d expected=5/4", wr_count, pad_seen); end
    endtask

    initial begin
        bus.rx_flag          = 1'b0;
        bus.rx_data          = 8'h00;
        bus.fifo_wr_rst_busy = 1'b0;
        test_reset();
        test_full_burst();
        test_half_flush();
        test_single_len1();
        test_pad_hold();
        test_busy();
        test_reset_in_pad();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
